muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have a parameter XLEN, default 32, giving the operand and result width.
REQ-002 SHALL have a parameter ITER, default 32, giving the number of iteration cycles; ITER SHALL equal XLEN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: the EX stage holds an M-extension op this cycle.
REQ-006 SHALL have port op, input, 3 bits: the funct3 encoding MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (0-7).
REQ-007 SHALL have port srca, input, XLEN bits: the forwarded operand A (rs1).
REQ-008 SHALL have port srcb, input, XLEN bits: the forwarded operand B (rs2).
REQ-009 SHALL have port flush, input, 1 bit: the EX-stage flush from the hazard unit.
REQ-010 SHALL have port stall, output, 1 bit: holds the PC, IF/ID and ID/EX registers while high.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse while result is valid.
REQ-012 SHALL have port result, output, XLEN bits: the M-op result, muxed into the ex_mem aluresult by the parent.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE with start=1 and flush=0, SHALL latch op, srca and srcb and go to MUL (op<4) or to DIV (op>=4).
REQ-015 In IDLE, SHALL go directly to DONE on the next edge, without iterating, when srcb==0 or on signed overflow (DIV/REM with srca=0x80000000 and srcb=0xFFFFFFFF).
REQ-016 MUL SHALL perform radix-2 shift-add on the unsigned magnitudes for exactly ITER cycles, producing a 2*XLEN-bit product, then go to DONE.
REQ-017 DIV SHALL perform restoring shift-subtract on the unsigned magnitudes for exactly ITER cycles, producing the quotient and remainder, then go to DONE.
REQ-018 Sign handling: MUL and MULH treat both operands as signed, MULHSU treats A as signed and B as unsigned, MULHU/DIVU/REMU treat both as unsigned; the product sign is signA^signB, the quotient sign is signA^signB, and the remainder takes the sign of A; negation is applied in DONE.
REQ-019 result selection: MUL gives product[XLEN-1:0]; MULH, MULHSU and MULHU give product[2*XLEN-1:XLEN]; DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-020 Divide by zero SHALL give quotient=0xFFFFFFFF and remainder=srca.
REQ-021 Signed overflow SHALL give quotient=0x80000000 and remainder=0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Latency: a start sampled at edge 0 SHALL give done at cycle ITER+1 on the iterating path and at cycle 1 on the fast path.
REQ-024 stall SHALL be the combinational signal (state==IDLE & start & ~flush) | state==MUL | state==DIV.
REQ-025 stall SHALL be 0 in DONE so that the EX instruction advances while capturing result.
REQ-026 In DONE, start SHALL be ignored; the op advancing out of EX guarantees no re-trigger.
REQ-027 In MUL/DIV, start SHALL be ignored and the latched operands SHALL be unaffected by changes on srca/srcb.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge with no done pulse.
REQ-029 flush SHALL take priority over start and over completion.
REQ-030 done and result SHALL be registered outputs; result SHALL hold its last value outside DONE.
REQ-031 The iteration counter SHALL be ceil(log2(ITER))+1 bits and SHALL reset to 0 on every IDLE exit.

Reset
REQ-032 With rst_n=0 at a rising edge, SHALL set state=IDLE, done=0, result=0 and all counters and accumulators to 0.
REQ-033 Reset asserted mid-iteration SHALL abort the op with no done pulse.
REQ-034 While in reset, stall SHALL be 0.

Structure
REQ-035 The muldiv_op_e enum (funct3 values) and the state enum SHALL live in the shared core package, alongside the id_ex_t and ex_mem_t types.
REQ-036 A single sub-module, muldiv_datapath (operand magnitude/sign capture, shift-add/subtract step, final negate), SHALL be used; FSM, counter and stall SHALL stay in muldiv_sequencer.
REQ-037 The block SHALL contain no other hierarchy.

Verification
REQ-038 MUL, srca=7, srcb=-3 (0xFFFFFFFD): stall high cycles 0..32; done at cycle 33; result=0xFFFFFFEB.
REQ-039 MULHU, srca=srcb=0xFFFFFFFF: result=0xFFFFFFFE; MULH on the same operands: result=0x00000000.
REQ-040 DIV, srca=-7, srcb=2: result=0xFFFFFFFD; REM on the same operands: result=0xFFFFFFFF.
REQ-041 DIVU, srcb=0, srca=0x1234: done at cycle 1, result=0xFFFFFFFF; REMU on the same operands: result=0x1234.
REQ-042 DIV, srca=0x80000000, srcb=-1: done at cycle 1, result=0x80000000; REM on the same operands: result=0.
REQ-043 flush at cycle 10 of a DIV: IDLE at cycle 11, no done pulse; a new MUL 3x4 started next returns 12.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared core types for the EX-stage M-extension unit: funct3 encodings,
// sequencer states, pipeline register layouts and operand-sign helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        is_muldiv;
    logic        regwrite;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic        regwrite;
  } ex_mem_t;

  // Operand A is interpreted as signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is interpreted as signed for MUL, MULH, DIV, REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Signed divide ops are the only ones that can overflow.
  function automatic logic op_div_signed(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer connection. The pipeline side is the
// master (issues ops, flushes); the sequencer is the slave.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, srca, srcb, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, op, srca, srcb, flush,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Multiply/divide datapath: captures operand magnitudes and signs, performs one
// shift-add or restoring shift-subtract step per enabled cycle, and forms the
// signed, op-selected result on the final step (or on a fast-path capture).
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,   // IDLE exit: latch op and operands
  input  logic            step,      // one iteration this edge
  input  logic            finish,    // this step is the last one
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            fast,      // no iteration needed for these operands
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // hi/lo hold the running product (upper/lower half) for multiplies and the
  // partial remainder/quotient for divides; b_reg is multiplicand or divisor.
  logic [2:0]      op_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic [XLEN-1:0] result_reg;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] hi_step, lo_step;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   final_res;

  // Operand sign/magnitude split and fast-path detection on the raw inputs.
  always_comb begin
    a_neg    = op_a_signed(op_in) & srca[XLEN-1];
    b_neg    = op_b_signed(op_in) & srcb[XLEN-1];
    a_mag    = a_neg ? -srca : srca;
    b_mag    = b_neg ? -srcb : srcb;
    div_zero = (srcb == '0);
    div_ovf  = op_div_signed(op_in) & (srca == MIN_NEG) & (srcb == '1);
    fast     = div_zero | div_ovf;
    fast_res = '0;
    if (op_in[2]) begin
      if (div_zero) fast_res = op_in[1] ? srca : '1;
      else          fast_res = op_in[1] ? '0 : MIN_NEG;
    end
  end

  // Multiplicand gated by the current multiplier LSB, bit by bit.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
      assign addend[gi] = b_reg[gi] & lo_reg[0];
    end
  endgenerate

  // One iteration of either shift-add (multiply) or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + {1'b0, addend};
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ok    = ~div_diff[XLEN];
    if (op_reg[2]) begin
      hi_step = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_step = {lo_reg[XLEN-2:0], div_ok};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Sign correction and result selection applied to the post-step values, so
  // the registered result is ready in the same cycle done goes high.
  always_comb begin
    prod_s = neg_q_reg ? -{hi_step, lo_step} : {hi_step, lo_step};
    quo_s  = neg_q_reg ? -lo_step : lo_step;
    rem_s  = neg_r_reg ? -hi_step : hi_step;
    case (op_reg)
      OP_MUL:                      final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = quo_s;
      default:                     final_res = rem_s;
    endcase
  end

  // Operand capture, iteration state and the held result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg     <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else if (capture) begin
      op_reg    <= op_in;
      b_reg     <= b_mag;
      hi_reg    <= '0;
      lo_reg    <= a_mag;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      if (fast) result_reg <= fast_res;
    end else if (step) begin
      hi_reg <= hi_step;
      lo_reg <= lo_step;
      if (finish) result_reg <= final_res;
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative M-extension unit for the EX stage: FSM, iteration counter and
// pipeline stall; arithmetic lives in muldiv_datapath.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32   // must equal XLEN: one bit per iteration
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_sequencer_if.slave     bus
);

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          done_reg;
  logic          capture, busy, step, last, finish, fast;

  // Control decode; flush suppresses both capture and iteration.
  always_comb begin
    capture = (state_reg == S_IDLE) & bus.start & ~bus.flush;
    busy    = (state_reg == S_MUL) | (state_reg == S_DIV);
    step    = busy & ~bus.flush;
    last    = (cnt_reg == LAST);
    finish  = step & last;
  end

  // Next-state logic; flush overrides everything, start is only seen in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (capture) state_next = fast ? S_DONE : (bus.op[2] ? S_DIV : S_MUL);
      S_MUL,
      S_DIV:   if (last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // State, iteration counter and registered done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_next == S_DONE);
      if (state_reg == S_IDLE) cnt_reg <= '0;
      else if (step)           cnt_reg <= cnt_reg + 1'b1;
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .step    (step),
    .finish  (finish),
    .op_in   (bus.op),
    .srca    (bus.srca),
    .srcb    (bus.srcb),
    .fast    (fast),
    .result  (bus.result)
  );

  // Stall holds the front of the pipe while an op is accepted or iterating;
  // it drops in DONE so the EX instruction advances with the result.
  assign bus.stall = rst_n & (capture | busy);
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: stimulus pushes expected result and
// done cycle into a scoreboard; a negedge monitor pops on every done pulse.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam int ITER = 32;
  localparam int LAT_ITER = ITER + 1;
  localparam int LAT_FAST = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  logic [31:0] mon_res;
  int          mon_cyc;
  string       mon_name;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        mon_res  = exp_res_q.pop_front();
        mon_cyc  = exp_cyc_q.pop_front();
        mon_name = exp_name_q.pop_front();
        check({mon_name, "_result"}, bus.result, mon_res);
        check({mon_name, "_done_cycle"}, 32'(cyc), 32'(mon_cyc));
        $display("txn %s result=0x%08h exp=0x%08h cycle=%0d", mon_name, bus.result, mon_res, cyc);
      end
    end
  end

  // Issue one op and keep start high (as a stalled EX stage would) until done,
  // scrambling the operand buses once the op has been accepted.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int  stall_cnt;
    bit  seen;
    @(negedge clk);
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    bus.start = 1'b1;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + lat);
    exp_name_q.push_back(name);
    stall_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k <= lat + 5 && !seen; k++) begin
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        check({name, "_stall_in_done"}, 32'(bus.stall), 32'd0);
      end else begin
        if (bus.stall === 1'b1) stall_cnt++;
        @(negedge clk);
        if (k == 0) begin
          bus.srca = $urandom;
          bus.srcb = $urandom;
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, lat + 5);
      exp_res_q.delete();
      exp_cyc_q.delete();
      exp_name_q.delete();
    end
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_done_pulse_len"}, 32'(bus.done), 32'd0);
    check({name, "_result_hold"}, bus.result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.srca  = '0;
    bus.srcb  = '0;

    // Reset: stall must stay low even with start asserted.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.srca  = 32'd5;
    bus.srcb  = 32'd6;
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("idle_stall", 32'(bus.stall), 32'd0);

    run_op("mul_7x-3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_ITER);
    run_op("mulhu_max",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_ITER);
    run_op("mulh_-1x-1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_ITER);
    run_op("mulhsu_-1xmax", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_ITER);
    run_op("div_-7/2",      OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_ITER);
    run_op("rem_-7/2",      OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_ITER);
    run_op("div_7/-2",      OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_ITER);
    run_op("rem_7/-2",      OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LAT_ITER);
    run_op("divu_100/7",    OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_ITER);
    run_op("remu_100/7",    OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_ITER);
    run_op("divu_by0",      OP_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, LAT_FAST);
    run_op("remu_by0",      OP_REMU,   32'h1234,     32'd0,        32'h1234,     LAT_FAST);
    run_op("rem_-5_by0",    OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_FAST);
    run_op("div_ovf",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST);
    run_op("rem_ovf",       OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_FAST);

    // Flush at cycle 10 of a DIV: back to IDLE at cycle 11, no done pulse.
    @(negedge clk);
    bus.op    = OP_DIVU;
    bus.srca  = 32'd1000;
    bus.srcb  = 32'd3;
    bus.start = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("flush_div_stall_c10", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check("flush_idle_stall_c11", 32'(bus.stall), 32'd0);
    repeat (40) @(negedge clk);
    run_op("mul_3x4_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, LAT_ITER);

    // Flush in IDLE beats start: nothing is accepted.
    @(negedge clk);
    bus.op    = OP_MUL;
    bus.srca  = 32'd9;
    bus.srcb  = 32'd9;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("flush_idle_start_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);

    // Reset mid-iteration aborts the op and clears the result.
    @(negedge clk);
    bus.op    = OP_MUL;
    bus.srca  = 32'd5;
    bus.srcb  = 32'd6;
    bus.start = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b0;
    #1;
    check("midop_reset_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midop_reset_result", bus.result, 32'd0);
    check("midop_reset_done", 32'(bus.done), 32'd0);
    repeat (40) @(negedge clk);

    run_op("mul_5x0_fast", OP_MUL, 32'd5, 32'd0, 32'd0, LAT_FAST);
    run_op("mul_-6x-7",    OP_MUL, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'd42, LAT_ITER);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
